dcache_miss_controller: RTL and testbench

- Sequencing FSM for the data cache in the MEM stage.
- Resolves each load/store from the pipeline as a hit or a miss.
- On a miss, writes back a dirty victim line and refills the line from main memory word by word.
- Drives the cache/memory control strobes (we_cache, we_memory, cache_input_type, memory_address_type, set_dirty, set_valid) and a stall to freeze the pipeline while the miss is serviced.

---
 rtl/dcache_miss_controller.sv | 150 +++++++++++++++
 tb/tb_dcache_miss_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_controller.sv
// Data-cache miss sequencer: resolves hits in IDLE, writes back dirty victims, refills lines word by word.
// Optional macro DCACHE_PERF_CNT_EN adds hit/miss/writeback event counters.
module dcache_miss_controller #(
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 4,
  parameter int IDX_W       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic             cache_hit,
  input  logic             cache_dirty,
  input  logic             halted,
  output logic             stall,
  output logic             done,
  output logic             we_cache,
  output logic             cache_input_type,
  output logic             memory_address_type,
  output logic             we_memory,
  output logic             set_dirty,
  output logic             set_valid,
  output logic [IDX_W-1:0] word_idx,
`ifdef DCACHE_PERF_CNT_EN
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count,
  output logic [31:0]      wb_count,
`endif
  output logic [1:0]       fsm_state
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, REFILL = 2'd2, RETRY = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             req_act, xfer, last_word;

  assign fsm_state = state;
  // Reset is folded in so the Mealy IDLE outputs are quiet while rst_b is low.
  assign req_act   = req_valid && !halted && rst_b;
  assign xfer      = (lat_cnt == LAT_LAST);
  assign last_word = (word_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      word_idx <= '0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_nxt;
      word_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    lat_nxt             = lat_cnt;
    idx_nxt             = word_idx;
    stall               = 1'b0;
    done                = 1'b0;
    we_cache            = 1'b0;
    cache_input_type    = 1'b0;
    memory_address_type = 1'b0;
    we_memory           = 1'b0;
    set_dirty           = 1'b0;
    set_valid           = 1'b0;
    case (state)
      IDLE: begin
        if (req_act) begin
          if (cache_hit) begin
            done = 1'b1;
            if (req_write) begin
              we_cache  = 1'b1;
              set_valid = 1'b1;
              set_dirty = 1'b1;
            end
          end else begin
            stall     = 1'b1;
            state_nxt = cache_dirty ? WB : REFILL;
          end
        end
      end
      WB: begin
        stall               = 1'b1;
        memory_address_type = 1'b1;
        if (xfer) begin
          we_memory = 1'b1;
          lat_nxt   = '0;
          if (last_word) begin
            idx_nxt   = '0;
            state_nxt = REFILL;
          end else begin
            idx_nxt = word_idx + IDX_W'(1);
          end
        end else begin
          lat_nxt = lat_cnt + LAT_W'(1);
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (xfer) begin
          we_cache         = 1'b1;
          cache_input_type = 1'b1;
          // Line becomes valid only with its final word.
          set_valid        = last_word;
          lat_nxt          = '0;
          if (last_word) begin
            idx_nxt   = '0;
            state_nxt = RETRY;
          end else begin
            idx_nxt = word_idx + IDX_W'(1);
          end
        end else begin
          lat_nxt = lat_cnt + LAT_W'(1);
        end
      end
      RETRY: begin
        stall     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  logic from_retry;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      from_retry <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      from_retry <= (state == RETRY);
      // A done right after RETRY completes a miss, not a hit.
      if (state == IDLE && done && !from_retry) hit_count <= hit_count + 32'd1;
      if (state == IDLE && state_nxt != IDLE)   miss_count <= miss_count + 32'd1;
      if (state == IDLE && state_nxt == WB)     wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_miss_controller.sv
// Directed bench for dcache_miss_controller at LINE_WORDS=4, MEM_LATENCY=4.
module tb_dcache_miss_controller;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       req_valid = 1'b0, req_write = 1'b0, cache_hit = 1'b0;
  logic       cache_dirty = 1'b0, halted = 1'b0;
  logic       stall, done, we_cache, cache_input_type, memory_address_type;
  logic       we_memory, set_dirty, set_valid;
  logic [1:0] word_idx, fsm_state;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_miss_controller #(.LINE_WORDS(4), .MEM_LATENCY(4)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_write(req_write),
    .cache_hit(cache_hit), .cache_dirty(cache_dirty), .halted(halted),
    .stall(stall), .done(done), .we_cache(we_cache), .cache_input_type(cache_input_type),
    .memory_address_type(memory_address_type), .we_memory(we_memory),
    .set_dirty(set_dirty), .set_valid(set_valid), .word_idx(word_idx),
`ifdef DCACHE_PERF_CNT_EN
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
`endif
    .fsm_state(fsm_state)
  );

  // {stall, done, we_cache, we_memory, cache_input_type, memory_address_type, set_dirty, set_valid, word_idx}
  logic [9:0] obs;
  assign obs = {stall, done, we_cache, we_memory, cache_input_type,
                memory_address_type, set_dirty, set_valid, word_idx};

  // Expected outputs at cycle c of a miss that starts in IDLE at cycle 0.
  function automatic logic [9:0] exp_vec(int c, bit dirty, bit wr);
    int rs, re, rt;
    logic st, dn, wc, wm, cit, mat, sd, sv;
    logic [1:0] w;
    rs = dirty ? 17 : 1;
    re = rs + 15;
    rt = re + 1;
    st = (c <= rt); dn = 0; wc = 0; wm = 0; cit = 0; mat = 0; sd = 0; sv = 0; w = 0;
    if (c >= 1 && c < rs) begin
      mat = 1;
      w   = 2'((c - 1) / 4);
      wm  = ((c - 1) % 4 == 3);
    end else if (c >= rs && c <= re) begin
      w   = 2'((c - rs) / 4);
      wc  = ((c - rs) % 4 == 3);
      cit = wc;
      sv  = wc && (w == 2'd3);
    end else if (c == rt + 1) begin
      dn = 1;
      if (wr) begin wc = 1; sd = 1; sv = 1; end
    end
    return {st, dn, wc, wm, cit, mat, sd, sv, w};
  endfunction

  task automatic to_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_write = 0; cache_hit = 0; cache_dirty = 0; halted = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_b = 0;
    #12;
    checks++;
    if (obs !== 10'd0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset outputs got %b/%0d exp %b/0", obs, fsm_state, 10'd0);
    end
    to_cycle();
    rst_b = 1;
    @(negedge clk);
  endtask

  task automatic test_load_hit();
    to_cycle();
    req_valid = 1; req_write = 0; cache_hit = 1;
    @(negedge clk);
    checks++;
    if (obs !== 10'b01_0000_0000) begin
      errors++;
      $display("FAIL load_hit got %b exp %b", obs, 10'b01_0000_0000);
    end
  endtask

  task automatic test_store_hit();
    to_cycle();
    req_valid = 1; req_write = 1; cache_hit = 1;
    @(negedge clk);
    checks++;
    if (obs !== 10'b01_1000_1100) begin
      errors++;
      $display("FAIL store_hit got %b exp %b", obs, 10'b01_1000_1100);
    end
    to_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (obs !== 10'd0) begin
      errors++;
      $display("FAIL no_request got %b exp %b", obs, 10'd0);
    end
  endtask

  task automatic test_halted();
    to_cycle();
    req_valid = 1; req_write = 1; cache_hit = 0; cache_dirty = 1; halted = 1;
    @(negedge clk);
    checks++;
    if (obs !== 10'd0) begin
      errors++;
      $display("FAIL halted_miss got %b exp %b", obs, 10'd0);
    end
    to_cycle();
    cache_hit = 1;
    @(negedge clk);
    checks++;
    if (obs !== 10'd0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL halted_idle got %b/%0d exp %b/0", obs, fsm_state, 10'd0);
    end
    to_cycle();
    idle_inputs();
  endtask

  // Clean load miss; halted pulses mid-miss and must be ignored.
  task automatic test_clean_miss();
    logic [9:0] e;
    for (int c = 0; c <= 19; c++) begin
      to_cycle();
      req_valid = (c <= 18); req_write = 0; cache_dirty = 0;
      cache_hit = (c >= 17);
      halted = (c >= 5 && c <= 12);
      @(negedge clk);
      e = (c <= 18) ? exp_vec(c, 0, 0) : 10'd0;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL clean_miss cyc %0d got %b exp %b", c, obs, e);
      end
    end
    idle_inputs();
  endtask

  // Dirty store miss; cache_dirty toggles randomly after IDLE and must be ignored.
  task automatic test_dirty_store_miss();
    logic [9:0] e;
    for (int c = 0; c <= 35; c++) begin
      to_cycle();
      req_valid = (c <= 34); req_write = 1;
      cache_dirty = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cache_hit = (c >= 33);
      @(negedge clk);
      e = (c <= 34) ? exp_vec(c, 1, 1) : 10'd0;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL dirty_miss cyc %0d got %b exp %b", c, obs, e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_req_drop();
    logic [9:0] e;
    for (int c = 0; c <= 22; c++) begin
      to_cycle();
      req_valid = (c < 3); req_write = 0; cache_dirty = 0;
      cache_hit = (c >= 17);
      @(negedge clk);
      e = (c < 18) ? exp_vec(c, 0, 0) : 10'd0;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL req_drop cyc %0d got %b exp %b", c, obs, e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_refill();
    bit sv_seen = 0;
    for (int c = 0; c <= 9; c++) begin
      to_cycle();
      req_valid = 1; req_write = 0; cache_dirty = 0; cache_hit = 0;
      @(negedge clk);
      sv_seen |= set_valid;
    end
    to_cycle();
    checks++;
    if (word_idx !== 2'd2 || stall !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_refill got idx %0d stall %b exp idx 2 stall 1", word_idx, stall);
    end
    rst_b = 0;
    #1;
    checks++;
    if (stall !== 0 || we_cache !== 0 || word_idx !== 0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_refill got %b/%0d exp %b/0", obs, fsm_state, 10'd0);
    end
    to_cycle();
    rst_b = 1;
    idle_inputs();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      sv_seen |= set_valid;
      to_cycle();
    end
    @(negedge clk);
    checks++;
    if (sv_seen !== 1'b0 || fsm_state !== 2'd0 || obs !== 10'd0) begin
      errors++;
      $display("FAIL after_reset got sv %b state %0d obs %b exp sv 0 state 0 obs %b",
               sv_seen, fsm_state, obs, 10'd0);
    end
  endtask

`ifdef DCACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    to_cycle();
    rst_b = 0;
    #2;
    rst_b = 1;
    for (int c = 0; c < 3; c++) begin
      to_cycle();
      req_valid = 1; req_write = c[0]; cache_hit = 1;
    end
    for (int c = 0; c <= 35; c++) begin
      to_cycle();
      req_valid = (c <= 34); req_write = 1; cache_dirty = (c == 0);
      cache_hit = (c >= 33);
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (hit_count !== 32'd3 || miss_count !== 32'd1 || wb_count !== 32'd1) begin
      errors++;
      $display("FAIL perf_counters got %0d/%0d/%0d exp 3/1/1", hit_count, miss_count, wb_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_hit();
    test_store_hit();
    test_halted();
    test_clean_miss();
    test_dirty_store_miss();
    test_req_drop();
    test_reset_mid_refill();
`ifdef DCACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
